// File: rtl/key_matrix_scanner.sv
// Row/column keypad scanner with tick-based debounce, press/release/held reporting and multi-key flagging.
// Optional auto-repeat of key_press while held is enabled by defining KEYPAD_AUTO_REPEAT_EN.
module key_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 800000,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int REPEAT_DELAY   = 60,
    parameter int REPEAT_RATE    = 15
) (
    input  logic                            clk,
    input  logic                            reset_p,
    input  logic [ROWS-1:0]                 row,
    output logic [COLS-1:0]                 col,
    output logic [$clog2(ROWS*COLS)-1:0]    key_code,
    output logic                            key_press,
    output logic                            key_release,
    output logic                            key_held,
    output logic                            multi_key
);

    localparam int KW = $clog2(ROWS*COLS);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 2 ||
        DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("key_matrix_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {SCAN, PRESS_DB, PRESSED, RELEASE_DB} state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic            tick;
    logic [CW-1:0]   c_idx;
    logic [CW-1:0]   c_next;
    logic [ROWS-1:0] cap_row;
    logic [3:0]      db_cnt;
    logic [4:0]      db_inc;
    logic            db_done;
    logic [3:0]      low_cnt;
    logic [RW-1:0]   row_idx;
    logic            row_idle;
    logic            row_single;
    logic            row_match;

    function automatic logic [COLS-1:0] col_drive(input logic [CW-1:0] idx);
        col_drive = ~(COLS'(1) << idx);
    endfunction

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign tick = (div == DW'(SCAN_DIV - 1));

    always_comb begin
        low_cnt = '0;
        row_idx = '0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (!row[i]) begin
                low_cnt = low_cnt + 4'd1;
                row_idx = RW'(i);
            end
        end
    end

    assign row_idle   = (low_cnt == 4'd0);
    assign row_single = (low_cnt == 4'd1);
    assign row_match  = (row == cap_row);
    assign c_next     = (c_idx == CW'(COLS - 1)) ? '0 : c_idx + 1'b1;
    assign db_inc     = {1'b0, db_cnt} + 5'd1;
    assign db_done    = (db_inc >= 5'(DEBOUNCE_TICKS));

`ifdef KEYPAD_AUTO_REPEAT_EN
    localparam int RPW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [RPW-1:0] rep_cnt;
    logic [RPW-1:0] rep_inc;
    logic           rep_armed;
    logic           rep_fire;

    // First repeat waits REPEAT_DELAY ticks; once armed, the same counter paces REPEAT_RATE.
    assign rep_inc  = rep_cnt + 1'b1;
    assign rep_fire = rep_armed ? (rep_inc >= RPW'(REPEAT_RATE)) : (rep_inc >= RPW'(REPEAT_DELAY));
`endif

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state       <= SCAN;
            c_idx       <= '0;
            col         <= {{(COLS-1){1'b1}}, 1'b0};
            cap_row     <= '1;
            db_cnt      <= '0;
            key_code    <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
            multi_key   <= 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
            rep_cnt     <= '0;
            rep_armed   <= 1'b0;
`endif
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_idle) begin
                            c_idx <= c_next;
                            col   <= col_drive(c_next);
                        end else if (row_single) begin
                            cap_row <= row;
                            db_cnt  <= 4'd1;
                            state   <= PRESS_DB;
                        end else begin
                            multi_key <= 1'b1;
                            c_idx     <= c_next;
                            col       <= col_drive(c_next);
                        end
                    end
                    PRESS_DB: begin
                        if (row_match) begin
                            db_cnt <= db_inc[3:0];
                            if (db_done) begin
                                key_code  <= KW'(c_idx) * KW'(ROWS) + KW'(row_idx);
                                key_press <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= PRESSED;
`ifdef KEYPAD_AUTO_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_armed <= 1'b0;
`endif
                            end
                        end else begin
                            c_idx <= c_next;
                            col   <= col_drive(c_next);
                            state <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (row_idle) begin
                            db_cnt <= 4'd1;
                            state  <= RELEASE_DB;
                        end else begin
`ifdef KEYPAD_AUTO_REPEAT_EN
                            if (rep_fire) begin
                                key_press <= 1'b1;
                                rep_cnt   <= '0;
                                rep_armed <= 1'b1;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
`endif
                        end
                    end
                    RELEASE_DB: begin
                        if (row_idle) begin
                            db_cnt <= db_inc[3:0];
                            if (db_done) begin
                                key_release <= 1'b1;
                                key_held    <= 1'b0;
                                c_idx       <= c_next;
                                col         <= col_drive(c_next);
                                state       <= SCAN;
                            end
                        end else if (row_match) begin
                            state <= PRESSED;
`ifdef KEYPAD_AUTO_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_armed <= 1'b0;
`endif
                        end else begin
                            db_cnt <= 4'd0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/key_matrix_scanner.md
KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of row inputs (2..8).
REQ-002 SHALL have parameter COLS, default 4, number of column outputs (2..8).
REQ-003 SHALL have parameter SCAN_DIV, default 800000, clk cycles per scan tick (>=2).
REQ-004 SHALL have parameter DEBOUNCE_TICKS, default 3, consecutive stable ticks required for press/release (1..15).
REQ-005 SHALL have parameter REPEAT_DELAY, default 60, ticks held before first auto-repeat.
REQ-006 SHALL have parameter REPEAT_RATE, default 15, ticks between auto-repeats.
REQ-007 SHALL have port: clk  input  1  system clock, rising edge.
REQ-008 SHALL have port: reset_p  input  1  reset, asynchronous, active-high.
REQ-009 SHALL have port: row  input  ROWS  active-low row sense, externally pulled up.
REQ-010 SHALL have port: col  output  COLS  active-low column drive, registered.
REQ-011 SHALL have port: key_code  output  clog2(ROWS*COLS)  code of the last debounced key.
REQ-012 SHALL have port: key_press  output  1  one-cycle pulse per accepted press or repeat.
REQ-013 SHALL have port: key_release  output  1  one-cycle pulse per debounced release.
REQ-014 SHALL have port: key_held  output  1  level, high while the accepted key is held.
REQ-015 SHALL have port: multi_key  output  1  one-cycle pulse when more than one row is low on a scan tick.

Function
REQ-016 Tick: free-running divider, one-clk pulse every SCAN_DIV clocks; all FSM transitions occur only on tick cycles.
REQ-017 Exactly one col bit SHALL be low at all times; col index c drives col = ~(1<<c).
REQ-018 key_code SHALL equal c*ROWS + r, where r is the index of the single low row bit.
REQ-019 FSM states: SCAN, PRESS_DB, PRESSED, RELEASE_DB.
REQ-020 SCAN, tick: row all-ones -> advance c (COLS-1 wraps to 0); exactly one low bit -> capture row, count=1, go PRESS_DB, c held; more than one low bit -> pulse multi_key, advance c, stay SCAN.
REQ-021 PRESS_DB, tick: row equals captured -> count+1; when count reaches DEBOUNCE_TICKS -> latch key_code, pulse key_press, set key_held, go PRESSED; row differs -> advance c, go SCAN, no outputs change.
REQ-022 PRESSED, tick: row all-ones -> count=1, go RELEASE_DB; otherwise stay (a second key on the same column is ignored).
REQ-023 RELEASE_DB, tick: row all-ones -> count+1; at DEBOUNCE_TICKS -> pulse key_release, clear key_held, advance c, go SCAN; row equals captured -> go PRESSED; other pattern -> stay, count=0.
REQ-024 With DEBOUNCE_TICKS=1, press is accepted on the tick after detection.
REQ-025 key_press and key_release SHALL never be high in the same cycle.
REQ-026 key_code SHALL hold its value until the next accepted press.

Reset
REQ-027 On reset_p high, asynchronously: state=SCAN, c=0 (col=~1), divider=0, count=0, key_code=0, key_press=0, key_release=0, key_held=0, multi_key=0.
REQ-028 Reset asserted in PRESSED or RELEASE_DB SHALL NOT produce key_release.

Configuration
REQ-029 Macro KEYPAD_AUTO_REPEAT_EN defined: in PRESSED, after REPEAT_DELAY ticks held, key_press SHALL pulse, then once every REPEAT_RATE ticks until leaving PRESSED; repeat counter clears on entry to PRESSED.
REQ-030 Macro undefined: exactly one key_press per press; REPEAT_DELAY and REPEAT_RATE are unused and no repeat logic is synthesised.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_TICKS=3 unless stated)
REQ-031 row=4'b1101 held while col=4'b1011 for 6 ticks -> one key_press pulse, key_code=9, key_held=1, col stays 4'b1011.
REQ-032 row=4'b1110 at col=4'b1110 for 1 tick then 4'b1111 -> no key_press, scanning resumes at col=4'b1101.
REQ-033 After REQ-031, row=4'b1111 for 3 ticks -> one key_release pulse, key_held=0, col=4'b0111 next.
REQ-034 row=4'b1100 on a scan tick -> multi_key one-cycle pulse, no key_press, col advances.
REQ-035 reset_p pulsed while key_held=1 -> all outputs zero immediately, col=4'b1110, no key_release.
REQ-036 KEYPAD_AUTO_REPEAT_EN, REPEAT_DELAY=4, REPEAT_RATE=2, key held 10 ticks after acceptance -> key_press pulses at acceptance and ticks 4, 6, 8, 10.
